// File: rtl/sblk_pkg.sv
// Shared defaults and width helpers for the superblock row dispatcher.
package sblk_pkg;

  localparam int N_ROW_DEF           = 3;
  localparam int WID_INST_DEF        = 14;
  localparam int WID_ACT_DEF         = 16;
  localparam int INST_FIFO_DEPTH_DEF = 4;
  localparam int ISSUE_GAP_DEF       = 2;

  localparam int FIFO_AW_DEF = $clog2(INST_FIFO_DEPTH_DEF);
  localparam int FIFO_CW_DEF = FIFO_AW_DEF + 1;
  localparam int HOLD_W_DEF  = $clog2(ISSUE_GAP_DEF + 1);
  localparam int RR_W_DEF    = $clog2(N_ROW_DEF);

  typedef enum logic {
    ACT_RR    = 1'b0,
    ACT_BCAST = 1'b1
  } act_mode_e;

  // Keeps index registers at least one bit wide when only one row exists.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sblk_inst_fifo.sv
// Per-row instruction FIFO; head word is presented on dout while not empty.
module sblk_inst_fifo
  import sblk_pkg::*;
#(
  parameter int WIDTH = WID_INST_DEF,
  parameter int DEPTH = INST_FIFO_DEPTH_DEF
) (
  input  logic                     clk_l,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses a push even when it is popped in the same cycle.
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk_l) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk_l) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sblk_row_dispatch.sv
// Distributes a masked instruction stream and an activation stream across a row of superblocks.
module sblk_row_dispatch
  import sblk_pkg::*;
#(
  parameter int N_ROW           = N_ROW_DEF,
  parameter int WID_INST        = WID_INST_DEF,
  parameter int WID_ACT         = WID_ACT_DEF,
  parameter int INST_FIFO_DEPTH = INST_FIFO_DEPTH_DEF,
  parameter int ISSUE_GAP       = ISSUE_GAP_DEF
) (
  input  logic                         clk_l,
  input  logic                         rst_n,
  input  logic [WID_INST-1:0]          inst_in_data,
  input  logic [N_ROW-1:0]             inst_in_mask,
  input  logic                         inst_in_vld,
  output logic                         inst_in_rdy,
  output logic [WID_INST*N_ROW-1:0]    inst_data,
  output logic [N_ROW-1:0]             inst_en,
  input  logic [N_ROW-1:0]             status_sblk,
  input  logic [2*WID_ACT-1:0]         act_src_data,
  input  logic                         act_src_vld,
  output logic                         act_src_rdy,
  input  logic                         act_bcast,
  output logic [2*WID_ACT*N_ROW-1:0]   act_data_in,
  output logic [N_ROW-1:0]             act_data_in_vld,
  input  logic [N_ROW-1:0]             act_data_in_req,
  output logic                         all_idle,
  output logic                         err_mask0
);

  localparam int CW = $clog2(INST_FIFO_DEPTH) + 1;
  localparam int HW = $clog2(ISSUE_GAP + 1);
  localparam int RW = width_of(N_ROW);
  localparam int BW = 2 * WID_ACT;

  logic [N_ROW-1:0]          fifo_push;
  logic [N_ROW-1:0]          fifo_full;
  logic [N_ROW-1:0]          fifo_empty;
  logic [WID_INST-1:0]       fifo_dout [N_ROW];
  logic [CW-1:0]             fifo_cnt  [N_ROW];
  logic [N_ROW-1:0]          row_issue;
  logic                      inst_acc;

  logic [WID_INST*N_ROW-1:0] inst_data_q, inst_data_d;
  logic [N_ROW-1:0]          inst_en_q;
  logic                      err_mask0_q;
  logic [HW-1:0]             holdoff_q [N_ROW];
  logic [HW-1:0]             holdoff_d [N_ROW];

  act_mode_e                 act_mode;
  logic                      act_acc;
  logic                      grant_found;
  logic [RW-1:0]             grant_idx;
  logic [RW-1:0]             rr_ptr_q, rr_ptr_d;
  logic [BW*N_ROW-1:0]       act_data_q, act_data_d;
  logic [N_ROW-1:0]          act_vld_q, act_vld_d;

  // Ready only looks at the rows this instruction targets.
  always_comb begin
    inst_in_rdy = 1'b1;
    for (int i = 0; i < N_ROW; i++) begin
      if (inst_in_mask[i] && fifo_full[i]) inst_in_rdy = 1'b0;
    end
  end

  assign inst_acc  = inst_in_vld & inst_in_rdy;
  assign fifo_push = {N_ROW{inst_acc}} & inst_in_mask;

  for (genvar g = 0; g < N_ROW; g++) begin : g_row
    sblk_inst_fifo #(
      .WIDTH (WID_INST),
      .DEPTH (INST_FIFO_DEPTH)
    ) u_fifo (
      .clk_l (clk_l),
      .rst_n (rst_n),
      .push  (fifo_push[g]),
      .pop   (row_issue[g]),
      .din   (inst_in_data),
      .dout  (fifo_dout[g]),
      .full  (fifo_full[g]),
      .empty (fifo_empty[g]),
      .count (fifo_cnt[g])
    );
  end

  // Holdoff masks the window before the row's busy flag reflects the issue.
  always_comb begin
    row_issue   = '0;
    inst_data_d = inst_data_q;
    holdoff_d   = holdoff_q;
    for (int i = 0; i < N_ROW; i++) begin
      row_issue[i] = !fifo_empty[i] && !status_sblk[i] && (holdoff_q[i] == '0);
      if (row_issue[i]) begin
        inst_data_d[i*WID_INST +: WID_INST] = fifo_dout[i];
        holdoff_d[i] = HW'(ISSUE_GAP);
      end else if (holdoff_q[i] != '0) begin
        holdoff_d[i] = holdoff_q[i] - HW'(1);
      end else begin
        holdoff_d[i] = '0;
      end
    end
  end

  assign act_mode    = act_mode_e'(act_bcast);
  assign act_src_rdy = (act_mode == ACT_BCAST) ? (&act_data_in_req) : (|act_data_in_req);
  assign act_acc     = act_src_vld & act_src_rdy;

  // Search from the pointer to the top row, then wrap to the rows below it.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < N_ROW; i++) begin
      if (!grant_found && act_data_in_req[i] && (RW'(i) >= rr_ptr_q)) begin
        grant_found = 1'b1;
        grant_idx   = RW'(i);
      end
    end
    for (int i = 0; i < N_ROW; i++) begin
      if (!grant_found && act_data_in_req[i] && (RW'(i) < rr_ptr_q)) begin
        grant_found = 1'b1;
        grant_idx   = RW'(i);
      end
    end
  end

  always_comb begin
    act_data_d = act_data_q;
    act_vld_d  = '0;
    rr_ptr_d   = rr_ptr_q;
    if (act_acc) begin
      if (act_mode == ACT_BCAST) begin
        for (int i = 0; i < N_ROW; i++) begin
          act_data_d[i*BW +: BW] = act_src_data;
        end
        act_vld_d = '1;
      end else begin
        for (int i = 0; i < N_ROW; i++) begin
          if (RW'(i) == grant_idx) begin
            act_data_d[i*BW +: BW] = act_src_data;
            act_vld_d[i]           = 1'b1;
          end
        end
        rr_ptr_d = (grant_idx == RW'(N_ROW - 1)) ? '0 : grant_idx + RW'(1);
      end
    end
  end

  always_ff @(posedge clk_l) begin
    if (!rst_n) begin
      inst_data_q <= '0;
      inst_en_q   <= '0;
      err_mask0_q <= 1'b0;
      act_data_q  <= '0;
      act_vld_q   <= '0;
      rr_ptr_q    <= '0;
      for (int i = 0; i < N_ROW; i++) begin
        holdoff_q[i] <= '0;
      end
    end else begin
      inst_data_q <= inst_data_d;
      inst_en_q   <= row_issue;
      err_mask0_q <= inst_acc && (inst_in_mask == '0);
      act_data_q  <= act_data_d;
      act_vld_q   <= act_vld_d;
      rr_ptr_q    <= rr_ptr_d;
      for (int i = 0; i < N_ROW; i++) begin
        holdoff_q[i] <= holdoff_d[i];
      end
    end
  end

  always_comb begin
    all_idle = (act_vld_q == '0) && (status_sblk == '0);
    for (int i = 0; i < N_ROW; i++) begin
      if ((fifo_cnt[i] != '0) || (holdoff_q[i] != '0)) all_idle = 1'b0;
    end
  end

  assign inst_data       = inst_data_q;
  assign inst_en         = inst_en_q;
  assign err_mask0       = err_mask0_q;
  assign act_data_in     = act_data_q;
  assign act_data_in_vld = act_vld_q;

endmodule

// File: tb/tb_sblk_row_dispatch.sv
// Scoreboard bench for sblk_row_dispatch at default parameters.
module tb_sblk_row_dispatch;

  localparam int NR = 3;
  localparam int WI = 14;
  localparam int BW = 32;

  logic              clk_l = 1'b0;
  logic              rst_n;
  logic [WI-1:0]     inst_in_data;
  logic [NR-1:0]     inst_in_mask;
  logic              inst_in_vld;
  logic              inst_in_rdy;
  logic [WI*NR-1:0]  inst_data;
  logic [NR-1:0]     inst_en;
  logic [NR-1:0]     status_sblk;
  logic [BW-1:0]     act_src_data;
  logic              act_src_vld;
  logic              act_src_rdy;
  logic              act_bcast;
  logic [BW*NR-1:0]  act_data_in;
  logic [NR-1:0]     act_data_in_vld;
  logic [NR-1:0]     act_data_in_req;
  logic              all_idle;
  logic              err_mask0;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [WI-1:0] iq0[$];
  logic [WI-1:0] iq1[$];
  logic [WI-1:0] iq2[$];

  typedef struct packed {
    logic [1:0]    row;
    logic [NR-1:0] vmask;
    logic [BW-1:0] data;
  } act_exp_t;
  act_exp_t aq[$];

  always #5 clk_l = ~clk_l;

  sblk_row_dispatch dut (
    .clk_l           (clk_l),
    .rst_n           (rst_n),
    .inst_in_data    (inst_in_data),
    .inst_in_mask    (inst_in_mask),
    .inst_in_vld     (inst_in_vld),
    .inst_in_rdy     (inst_in_rdy),
    .inst_data       (inst_data),
    .inst_en         (inst_en),
    .status_sblk     (status_sblk),
    .act_src_data    (act_src_data),
    .act_src_vld     (act_src_vld),
    .act_src_rdy     (act_src_rdy),
    .act_bcast       (act_bcast),
    .act_data_in     (act_data_in),
    .act_data_in_vld (act_data_in_vld),
    .act_data_in_req (act_data_in_req),
    .all_idle        (all_idle),
    .err_mask0       (err_mask0)
  );

  task automatic exp_push(input int r, input logic [WI-1:0] v);
    case (r)
      0: iq0.push_back(v);
      1: iq1.push_back(v);
      default: iq2.push_back(v);
    endcase
  endtask

  task automatic exp_pop(input int r, output logic [WI-1:0] v, output bit ok);
    ok = 1'b1;
    v  = '0;
    case (r)
      0: if (iq0.size() > 0) v = iq0.pop_front(); else ok = 1'b0;
      1: if (iq1.size() > 0) v = iq1.pop_front(); else ok = 1'b0;
      default: if (iq2.size() > 0) v = iq2.pop_front(); else ok = 1'b0;
    endcase
  endtask

  task automatic tick();
    @(posedge clk_l);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    inst_in_data = '0; inst_in_mask = '0; inst_in_vld = 1'b0;
    status_sblk = '0; act_src_data = '0; act_src_vld = 1'b0;
    act_bcast = 1'b0; act_data_in_req = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tests_run++;
    if ({inst_en, act_data_in_vld, err_mask0} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_pulses: got en=%b avld=%b err=%b want all 0", inst_en, act_data_in_vld, err_mask0);
    end
    tests_run++;
    if ({inst_data, act_data_in} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got inst=%h act=%h want 0", inst_data, act_data_in);
    end
    tests_run++;
    if ({all_idle, inst_in_rdy, act_src_rdy} !== 3'b110) begin
      tests_failed++;
      $display("FAIL reset_flags: got idle=%b irdy=%b ardy=%b want 1 1 0", all_idle, inst_in_rdy, act_src_rdy);
    end
  endtask

  task automatic test_bcast_fill();
    logic [NR-1:0] exp_en;
    logic [WI-1:0] v;
    bit ok;
    for (int k = 0; k < 18; k++) begin
      if (k < 5) begin
        inst_in_vld  = 1'b1;
        inst_in_mask = 3'b111;
        inst_in_data = WI'(k + 1);
        for (int r = 0; r < NR; r++) exp_push(r, WI'(k + 1));
      end else begin
        inst_in_vld = 1'b0;
      end
      #1;
      if (k < 5) begin
        tests_run++;
        if (inst_in_rdy !== 1'b1) begin
          tests_failed++;
          $display("FAIL fill_rdy k=%0d: got %b want 1", k, inst_in_rdy);
        end
      end
      tick();
      exp_en = ((k % 3 == 1) && (k <= 13)) ? 3'b111 : 3'b000;
      tests_run++;
      if (inst_en !== exp_en) begin
        tests_failed++;
        $display("FAIL fill_en k=%0d: got %b want %b", k, inst_en, exp_en);
      end
      for (int r = 0; r < NR; r++) begin
        if (exp_en[r]) begin
          exp_pop(r, v, ok);
          tests_run++;
          if (!ok || inst_data[r*WI +: WI] !== v) begin
            tests_failed++;
            $display("FAIL fill_data row%0d k=%0d: got %h want %h", r, k, inst_data[r*WI +: WI], v);
          end
        end
      end
    end
    tests_run++;
    if (inst_data !== {3{14'h005}}) begin
      tests_failed++;
      $display("FAIL fill_hold: got %h want %h", inst_data, {3{14'h005}});
    end
  endtask

  task automatic test_backpressure();
    logic exp_rdy;
    logic [NR-1:0] exp_en;
    logic [WI-1:0] v;
    bit ok;
    status_sblk = 3'b010;
    for (int k = 0; k < 6; k++) begin
      inst_in_vld  = 1'b1;
      inst_in_mask = 3'b010;
      inst_in_data = WI'(16 + k);
      #1;
      exp_rdy = (k < 4);
      tests_run++;
      if (inst_in_rdy !== exp_rdy) begin
        tests_failed++;
        $display("FAIL bp_rdy k=%0d: got %b want %b", k, inst_in_rdy, exp_rdy);
      end
      if (exp_rdy) exp_push(1, WI'(16 + k));
      tick();
      tests_run++;
      if (inst_en !== 3'b000) begin
        tests_failed++;
        $display("FAIL bp_busy_en k=%0d: got %b want 000", k, inst_en);
      end
    end
    inst_in_vld  = 1'b0;
    inst_in_mask = 3'b001;
    #1;
    tests_run++;
    if (inst_in_rdy !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_other_row_rdy: got %b want 1", inst_in_rdy);
    end
    inst_in_mask = 3'b010;
    #1;
    tests_run++;
    if (inst_in_rdy !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_full_rdy: got %b want 0", inst_in_rdy);
    end
    status_sblk = 3'b000;
    for (int k = 0; k < 12; k++) begin
      tick();
      exp_en = ((k % 3 == 0) && (k <= 9)) ? 3'b010 : 3'b000;
      tests_run++;
      if (inst_en !== exp_en) begin
        tests_failed++;
        $display("FAIL bp_drain_en k=%0d: got %b want %b", k, inst_en, exp_en);
      end
      if (exp_en[1]) begin
        exp_pop(1, v, ok);
        tests_run++;
        if (!ok || inst_data[WI +: WI] !== v) begin
          tests_failed++;
          $display("FAIL bp_drain_data k=%0d: got %h want %h", k, inst_data[WI +: WI], v);
        end
      end
    end
  endtask

  task automatic test_mask0();
    inst_in_vld  = 1'b1;
    inst_in_mask = 3'b000;
    inst_in_data = 14'h3ff;
    #1;
    tests_run++;
    if (inst_in_rdy !== 1'b1) begin
      tests_failed++;
      $display("FAIL mask0_rdy: got %b want 1", inst_in_rdy);
    end
    tick();
    inst_in_vld = 1'b0;
    tests_run++;
    if ({err_mask0, inst_en} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL mask0_pulse: got err=%b en=%b want 1 000", err_mask0, inst_en);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      tests_run++;
      if ({err_mask0, inst_en} !== 4'b0000) begin
        tests_failed++;
        $display("FAIL mask0_after k=%0d: got err=%b en=%b want 0 000", k, err_mask0, inst_en);
      end
    end
  endtask

  task automatic test_rr_unicast();
    act_exp_t e;
    act_bcast       = 1'b0;
    act_data_in_req = 3'b111;
    for (int k = 0; k < 9; k++) begin
      if (k == 6) act_data_in_req = 3'b100;
      act_src_vld  = 1'b1;
      act_src_data = (k < 6) ? (32'h0000_000a + 32'(k)) : (32'hc0de_0000 + 32'(k));
      e.row   = (k < 6) ? 2'(k % 3) : 2'd2;
      e.vmask = 3'b001 << e.row;
      e.data  = act_src_data;
      aq.push_back(e);
      #1;
      tests_run++;
      if (act_src_rdy !== 1'b1) begin
        tests_failed++;
        $display("FAIL rr_rdy k=%0d: got %b want 1", k, act_src_rdy);
      end
      tick();
      e = aq.pop_front();
      tests_run++;
      if (act_data_in_vld !== e.vmask || act_data_in[e.row*BW +: BW] !== e.data) begin
        tests_failed++;
        $display("FAIL rr_beat k=%0d: got vld=%b data=%h want vld=%b data=%h",
                 k, act_data_in_vld, act_data_in[e.row*BW +: BW], e.vmask, e.data);
      end
    end
    act_src_vld = 1'b0;
    tick();
    tests_run++;
    if (act_data_in_vld !== 3'b000) begin
      tests_failed++;
      $display("FAIL rr_idle: got %b want 000", act_data_in_vld);
    end
  endtask

  task automatic test_bcast_act();
    act_exp_t e;
    act_bcast       = 1'b1;
    act_data_in_req = 3'b011;
    act_src_vld     = 1'b1;
    act_src_data    = 32'h1234_5678;
    #1;
    tests_run++;
    if (act_src_rdy !== 1'b0) begin
      tests_failed++;
      $display("FAIL bc_partial_rdy: got %b want 0", act_src_rdy);
    end
    tick();
    tests_run++;
    if (act_data_in_vld !== 3'b000) begin
      tests_failed++;
      $display("FAIL bc_stalled_vld: got %b want 000", act_data_in_vld);
    end
    act_data_in_req = 3'b111;
    #1;
    tests_run++;
    if (act_src_rdy !== 1'b1) begin
      tests_failed++;
      $display("FAIL bc_full_rdy: got %b want 1", act_src_rdy);
    end
    tick();
    act_src_vld = 1'b0;
    tests_run++;
    if (act_data_in_vld !== 3'b111 || act_data_in !== {3{32'h1234_5678}}) begin
      tests_failed++;
      $display("FAIL bc_beat: got vld=%b data=%h want 111 %h", act_data_in_vld, act_data_in, {3{32'h1234_5678}});
    end
    act_bcast = 1'b0;
    tick();
    tests_run++;
    if (act_data_in_vld !== 3'b000) begin
      tests_failed++;
      $display("FAIL bc_after: got %b want 000", act_data_in_vld);
    end
    // Pointer was 0 before the broadcast and must still be 0.
    act_src_vld  = 1'b1;
    act_src_data = 32'h5555_aaaa;
    e.row = 2'd0; e.vmask = 3'b001; e.data = act_src_data;
    aq.push_back(e);
    tick();
    act_src_vld = 1'b0;
    e = aq.pop_front();
    tests_run++;
    if (act_data_in_vld !== e.vmask || act_data_in[e.row*BW +: BW] !== e.data) begin
      tests_failed++;
      $display("FAIL bc_ptr_kept: got vld=%b want %b", act_data_in_vld, e.vmask);
    end
  endtask

  task automatic test_mid_reset();
    status_sblk = 3'b111;
    for (int k = 0; k < 3; k++) begin
      inst_in_vld  = 1'b1;
      inst_in_mask = 3'b111;
      inst_in_data = WI'(14'h2a0 + k);
      tick();
    end
    inst_in_vld = 1'b0;
    tests_run++;
    if (all_idle !== 1'b0) begin
      tests_failed++;
      $display("FAIL mr_busy_idle: got %b want 0", all_idle);
    end
    rst_n = 1'b0;
    tick();
    rst_n       = 1'b1;
    status_sblk = 3'b000;
    iq0.delete(); iq1.delete(); iq2.delete();
    #1;
    tests_run++;
    if ({inst_data, act_data_in} !== '0 || {inst_en, act_data_in_vld, err_mask0} !== 7'b0) begin
      tests_failed++;
      $display("FAIL mr_outputs: got inst=%h act=%h en=%b avld=%b want 0", inst_data, act_data_in, inst_en, act_data_in_vld);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      tests_run++;
      if (inst_en !== 3'b000 || all_idle !== 1'b1) begin
        tests_failed++;
        $display("FAIL mr_quiet k=%0d: got en=%b idle=%b want 000 1", k, inst_en, all_idle);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bcast_fill();
    test_backpressure();
    test_mask0();
    test_rr_unicast();
    test_bcast_act();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
